// File: rtl/spi_pkg.sv
// Shared definitions for the SPI host: FSM encoding, chip-select defaults and
// the "no chip select" selector value.
package spi_pkg;

  localparam int         NUM_CS_DEFAULT = 3;
  localparam logic [1:0] SEL_NONE       = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_e;

endpackage

// File: rtl/spi_host_tick.sv
// Half-period timebase: a down-counter that strobes tick_o once every
// HALF_PERIOD cycles while enabled, and sits at its reload value otherwise.
module spi_host_tick #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] RELOAD = 8'(HALF_PERIOD - 1);

  logic [7:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else if (!en_i || cnt_q == 8'd0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign tick_o = en_i && (cnt_q == 8'd0);

endmodule

// File: rtl/spi_host.sv
// SPI mode-0 host: byte-wide command/response handshake, per-byte chip-select
// control with setup, switch gap and hold phases.
module spi_host
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int NUM_CS      = NUM_CS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_data,
  input  logic [1:0]        cmd_sel,
  input  logic              cmd_last,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic [NUM_CS-1:0] spi_cs,
  input  logic              spi_miso
);

  state_e            state_q;
  logic              cmd_ready_q, busy_q, rsp_valid_q, sck_q, last_q, gap_q;
  logic [7:0]        rsp_data_q, tx_q, rx_q;
  logic [3:0]        half_q;
  logic [1:0]        cur_sel_q, new_sel_q;
  logic [NUM_CS-1:0] cs_q;
  logic              tick;
  logic              accept;

  function automatic logic [NUM_CS-1:0] sel_to_cs(input logic [1:0] sel);
    logic [NUM_CS-1:0] cs;
    cs = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == 2'(i)) cs[i] = 1'b0;
    end
    return cs;
  endfunction

  spi_host_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  assign accept = cmd_valid && cmd_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      sck_q       <= 1'b0;
      tx_q        <= 8'h00;
      rx_q        <= 8'h00;
      half_q      <= 4'd0;
      last_q      <= 1'b0;
      gap_q       <= 1'b0;
      cur_sel_q   <= SEL_NONE;
      new_sel_q   <= SEL_NONE;
      cs_q        <= '1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            tx_q        <= cmd_data;
            last_q      <= cmd_last;
            half_q      <= 4'd0;
            new_sel_q   <= cmd_sel;
            if (cmd_sel == cur_sel_q) begin
              state_q <= SHIFT;
            end else begin
              state_q <= SETUP;
              // Switching slaves: release the old select for one half-period first.
              if (cur_sel_q == SEL_NONE) begin
                gap_q     <= 1'b0;
                cs_q      <= sel_to_cs(cmd_sel);
                cur_sel_q <= cmd_sel;
              end else begin
                gap_q     <= 1'b1;
                cs_q      <= '1;
                cur_sel_q <= SEL_NONE;
              end
            end
          end
        end
        SETUP: begin
          if (tick) begin
            if (gap_q) begin
              gap_q     <= 1'b0;
              cs_q      <= sel_to_cs(new_sel_q);
              cur_sel_q <= new_sel_q;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            half_q <= half_q + 4'd1;
            if (!half_q[0]) begin
              sck_q <= 1'b1;
              rx_q  <= {rx_q[6:0], spi_miso};
            end else begin
              sck_q <= 1'b0;
              if (half_q == 4'd15) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rx_q;
                if (last_q) begin
                  state_q <= HOLD;
                end else begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                end
              end else begin
                tx_q <= {tx_q[6:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_q        <= '1;
            cur_sel_q   <= SEL_NONE;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign spi_clk   = sck_q;
  assign spi_mosi  = tx_q[7];
  assign spi_cs    = cs_q;

endmodule

// File: tb/tb_spi_host.sv
// Directed bench for spi_host: one instance at HALF_PERIOD=2 with a shifting
// slave model, one at HALF_PERIOD=1 with spi_miso tied high.
module tb_spi_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_last;
  logic [7:0] cmd_data;
  logic [1:0] cmd_sel;
  logic       cmd_ready, rsp_valid, busy, spi_clk, spi_mosi, spi_miso;
  logic [7:0] rsp_data;
  logic [2:0] spi_cs;

  logic       b_cmd_valid, b_cmd_last;
  logic [7:0] b_cmd_data;
  logic [1:0] b_cmd_sel;
  logic       b_cmd_ready, b_rsp_valid, b_busy, b_spi_clk, b_spi_mosi;
  logic [7:0] b_rsp_data;
  logic [2:0] b_spi_cs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] slave_byte;
  logic [2:0] slave_idx;
  logic [7:0] mosi_cap = 8'h00, b_mosi_cap = 8'h00;

  int   rsp_cnt = 0, cs_overlap = 0, mosi_viol = 0, rb_viol = 0, b_cs_low = 0;
  int   cs1_high_seen = 0, cs0_rise_cyc = 0, cs2_fall_cyc = 0;
  int   ready_seen;
  logic watch1;
  logic [2:0] prev_cs = 3'b111;
  logic prev_mosi = 1'b0, b_prev_mosi = 1'b0;

  spi_host #(.HALF_PERIOD(2), .NUM_CS(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(spi_miso)
  );

  spi_host #(.HALF_PERIOD(1), .NUM_CS(3)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_data(b_cmd_data), .cmd_sel(b_cmd_sel), .cmd_last(b_cmd_last),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy),
    .spi_clk(b_spi_clk), .spi_mosi(b_spi_mosi), .spi_cs(b_spi_cs), .spi_miso(1'b1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave: presents MSB first, advances after each falling spi_clk.
  always @(negedge spi_clk or posedge rst) begin
    if (rst) slave_idx <= 3'd0;
    else     slave_idx <= slave_idx + 3'd1;
  end
  assign spi_miso = slave_byte[~slave_idx];

  always @(posedge spi_clk)   mosi_cap   <= {mosi_cap[6:0], spi_mosi};
  always @(posedge b_spi_clk) b_mosi_cap <= {b_mosi_cap[6:0], b_spi_mosi};

  always @(negedge clk) begin
    if ($countones(~spi_cs) > 1) cs_overlap <= cs_overlap + 1;
    if (b_spi_cs != 3'b111) b_cs_low <= b_cs_low + 1;
    if ((spi_mosi != prev_mosi) && spi_clk) mosi_viol <= mosi_viol + 1;
    if ((b_spi_mosi != b_prev_mosi) && b_spi_clk) mosi_viol <= mosi_viol + 1;
    if ((cmd_ready && busy) || (b_cmd_ready && b_busy)) rb_viol <= rb_viol + 1;
    if (spi_cs[0] && !prev_cs[0]) cs0_rise_cyc <= cyc;
    if (!spi_cs[2] && prev_cs[2]) cs2_fall_cyc <= cyc;
    if (watch1 && spi_cs[1]) cs1_high_seen <= cs1_high_seen + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    prev_cs     <= spi_cs;
    prev_mosi   <= spi_mosi;
    b_prev_mosi <= b_spi_mosi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a command, return its accept cycle; optionally keep cmd_valid high
  // for 'hold' further cycles with scrambled data.
  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l,
                      input int hold, output int acc);
    int n = 0;
    @(negedge clk);
    cmd_data = d; cmd_sel = s; cmd_last = l; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(cmd_ready), 32'h1);
    acc = cyc;
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      cmd_data = cmd_data + 8'h1D;
      if (cmd_ready) ready_seen++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int c, output logic [7:0] d);
    int n = 0;
    while (!rsp_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", 32'(rsp_valid), 32'h1);
    c = cyc;
    d = rsp_data;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(cmd_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, acc2, c, n, r0;
    logic [7:0] d;

    rst = 1'b1; watch1 = 1'b0; slave_byte = 8'h00;
    cmd_valid = 1'b0; cmd_data = 8'h00; cmd_sel = 2'd0; cmd_last = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_data = 8'h00; b_cmd_sel = 2'd3; b_cmd_last = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cs",        32'(spi_cs),    32'h7);
    check("rst_sck",       32'(spi_clk),   32'h0);
    check("rst_mosi",      32'(spi_mosi),  32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data",  32'(rsp_data),  32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_ready",     32'(cmd_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst",   32'(cmd_ready),   32'h1);
    check("b_ready_after_rst", 32'(b_cmd_ready), 32'h1);

    // 0xA5 to sel 0 with last, slave answers 0x3C.
    slave_byte = 8'h3C;
    send(8'hA5, 2'd0, 1'b1, 0, acc);
    wait_rsp(c, d);
    check("a5_latency", 32'(c - acc), 32'd35);
    check("a5_rsp",     32'(d),        32'h3C);
    check("a5_mosi",    32'(mosi_cap), 32'hA5);
    @(negedge clk);
    check("a5_cs_still_low", 32'(spi_cs), 32'h6);
    check("a5_ready_low",    32'(cmd_ready), 32'h0);
    @(negedge clk);
    check("a5_cs_released",  32'(spi_cs), 32'h7);
    check("a5_ready_back",   32'(cmd_ready), 32'h1);

    // Two bytes to sel 1, select held between them.
    slave_byte = 8'h11;
    send(8'h01, 2'd1, 1'b0, 0, acc);
    wait_rsp(c, d);
    check("b2b_rsp1",  32'(d),        32'h11);
    check("b2b_mosi1", 32'(mosi_cap), 32'h01);
    check("b2b_cs1_low", 32'(spi_cs), 32'h5);
    watch1 = 1'b1;
    slave_byte = 8'h22;
    send(8'h02, 2'd1, 1'b1, 0, acc2);
    wait_rsp(c, d);
    watch1 = 1'b0;
    check("b2b_latency2", 32'(c - acc2),    32'd33);
    check("b2b_rsp2",     32'(d),           32'h22);
    check("b2b_mosi2",    32'(mosi_cap),    32'h02);
    check("b2b_cs1_held", 32'(cs1_high_seen), 32'd0);
    wait_idle();

    // sel 0 without last, then switch to sel 2.
    slave_byte = 8'hE7;
    send(8'h33, 2'd0, 1'b0, 0, acc);
    wait_rsp(c, d);
    check("sw_rsp1", 32'(d), 32'hE7);
    slave_byte = 8'h4B;
    send(8'hC3, 2'd2, 1'b1, 0, acc);
    wait_rsp(c, d);
    check("sw_cs0_rise",  32'(cs0_rise_cyc - acc),          32'd1);
    check("sw_gap",       32'(cs2_fall_cyc - cs0_rise_cyc), 32'd2);
    check("sw_latency",   32'(c - acc),                     32'd37);
    check("sw_rsp2",      32'(d),                           32'h4B);
    check("sw_mosi2",     32'(mosi_cap),                    32'hC3);
    wait_idle();

    // cmd_valid held through the transfer with changing data.
    slave_byte = 8'h96;
    ready_seen = 0;
    r0 = rsp_cnt;
    send(8'h6C, 2'd0, 1'b1, 20, acc);
    wait_rsp(c, d);
    check("hold_ready_low", 32'(ready_seen), 32'd0);
    check("hold_mosi",      32'(mosi_cap),   32'h6C);
    check("hold_rsp",       32'(d),          32'h96);
    wait_idle();
    repeat (10) @(negedge clk);
    check("hold_one_rsp", 32'(rsp_cnt - r0), 32'd1);
    check("hold_not_busy", 32'(busy),        32'h0);

    // Reset while bit 4 is high on the wire.
    slave_byte = 8'h00;
    r0 = rsp_cnt;
    send(8'h5A, 2'd0, 1'b1, 0, acc);
    n = 0;
    while (cyc < acc + 21 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_sck_high", 32'(spi_clk), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_cs",        32'(spi_cs),    32'h7);
    check("abort_sck",       32'(spi_clk),   32'h0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort_busy",      32'(busy),      32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_rsp",  32'(rsp_cnt - r0), 32'd0);
    check("abort_ready",   32'(cmd_ready),    32'h1);
    slave_byte = 8'h81;
    send(8'hFF, 2'd0, 1'b1, 0, acc);
    wait_rsp(c, d);
    check("post_abort_latency", 32'(c - acc),    32'd35);
    check("post_abort_rsp",     32'(d),          32'h81);
    check("post_abort_mosi",    32'(mosi_cap),   32'hFF);
    wait_idle();

    // HALF_PERIOD=1 instance, no chip select, spi_miso tied high.
    @(negedge clk);
    b_cmd_data = 8'h5A; b_cmd_sel = 2'd3; b_cmd_last = 1'b0; b_cmd_valid = 1'b1;
    n = 0;
    while (!b_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hp1_accept", 32'(b_cmd_ready), 32'h1);
    acc = cyc;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    n = 0;
    while (!b_rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hp1_rsp_timeout", 32'(b_rsp_valid), 32'h1);
    check("hp1_latency",     32'(cyc - acc),   32'd17);
    check("hp1_rsp",         32'(b_rsp_data),  32'hFF);
    check("hp1_mosi",        32'(b_mosi_cap),  32'h5A);
    repeat (3) @(negedge clk);
    check("hp1_no_cs",       32'(b_cs_low),    32'd0);

    check("cs_overlap",   32'(cs_overlap), 32'd0);
    check("mosi_in_high", 32'(mosi_viol),  32'd0);
    check("ready_busy",   32'(rb_viol),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
